// File: rtl/irq_sched.sv
`default_nettype none
// ============================================================================
// Module      : irq_sched
// Description : Interrupt scheduler between the I/O devices and cp0.
//               Owns a free-running 32-bit cycle counter with a compare
//               register (timer source, pending bit 0). It edge-detects NSRC
//               external lines (pending bits 1..NSRC), applies a mask, and
//               drives the single request line into cp0 TimerInterrupt.
//               Software accesses it through five memory-mapped words at BASE:
//                 +0  CYCLE (RO)   +4  CMP (RW)   +8  PEND (RO, W1C)
//                 +12 MASK  (RW)   +16 CLAIM (RO, read claims lowest bit)
// Ports       : clock    - rising-edge clock
//               reset    - asynchronous active-low reset
//               address  - byte address from the datapath ALU
//               wr_data  - store data
//               MemRead  - load strobe
//               MemWrite - store strobe
//               irq_src  - external interrupt lines, level, active-high
//               rd_data  - load data, 0 when this block is not read
//               hit      - address decodes to one of the five registers
//               irq      - |(pend & mask), to cp0 TimerInterrupt
// Config      : `define IRQ_SCHED_SYNC_EN adds a 2-flop synchronizer on
//               irq_src ahead of the edge detector (+2 cycles of latency).
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sched #(
    parameter int unsigned NSRC = 4,
    parameter logic [31:0] BASE = 32'hffff0020
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     address,
    input  logic [31:0]     wr_data,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [NSRC-1:0] irq_src,
    output logic [31:0]     rd_data,
    output logic            hit,
    output logic            irq
);

    localparam int unsigned c_W         = NSRC + 1;
    localparam logic [2:0]  c_SEL_CYCLE = 3'd0;
    localparam logic [2:0]  c_SEL_CMP   = 3'd1;
    localparam logic [2:0]  c_SEL_PEND  = 3'd2;
    localparam logic [2:0]  c_SEL_MASK  = 3'd3;
    localparam logic [2:0]  c_SEL_CLAIM = 3'd4;

    logic [31:0]     r_cycle;
    logic [31:0]     r_cmp;
    logic [c_W-1:0]  r_pend;
    logic [c_W-1:0]  r_mask;
    logic [NSRC-1:0] r_prev;

    logic [NSRC-1:0] w_src;
    logic [31:0]     w_off;
    logic [2:0]      w_sel;
    logic            w_rd;
    logic            w_wr;
    logic [c_W-1:0]  w_active;
    logic [c_W-1:0]  w_first;
    logic [4:0]      w_idx;
    logic            w_any;
    logic            w_claim;
    logic [c_W-1:0]  w_set;
    logic [c_W-1:0]  w_clr;

    // ------------------------------------------------------------------
    // Optional input synchronizer
    // ------------------------------------------------------------------
`ifdef IRQ_SCHED_SYNC_EN
    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = irq_src;
`endif

    // ------------------------------------------------------------------
    // Address decode. Subtracting BASE first makes addresses below BASE
    // wrap to large offsets, so a single upper-bound compare covers both
    // ends of the window.
    // ------------------------------------------------------------------
    assign w_off = address - BASE;
    assign hit   = (w_off[1:0] == 2'b00) && (w_off <= 32'd16);
    assign w_sel = w_off[4:2];
    assign w_rd  = MemRead && hit;
    assign w_wr  = MemWrite && hit;

    // ------------------------------------------------------------------
    // Lowest-numbered active bit for CLAIM
    // ------------------------------------------------------------------
    assign w_active = r_pend & r_mask;
    assign irq      = |w_active;

    always_comb begin
        w_idx   = '0;
        w_first = '0;
        w_any   = 1'b0;
        for (int i = 0; i < int'(c_W); i++) begin
            if (w_active[i] && !w_any) begin
                w_idx      = 5'(i);
                w_first[i] = 1'b1;
                w_any      = 1'b1;
            end
        end
    end

    assign w_claim = w_rd && (w_sel == c_SEL_CLAIM) && w_any;

    // Timer match uses the pre-edge counter and compare values.
    assign w_set = {w_src & ~r_prev, (r_cycle == r_cmp)};
    assign w_clr = ((w_wr && (w_sel == c_SEL_PEND)) ? wr_data[c_W-1:0] : '0)
                 | (w_claim ? w_first : '0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle <= '0;
            r_cmp   <= '1;
            r_pend  <= '0;
            r_mask  <= '0;
            r_prev  <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            r_prev  <= w_src;
            // Set has priority over a same-cycle clear.
            r_pend  <= (r_pend & ~w_clr) | w_set;
            if (w_wr && (w_sel == c_SEL_CMP)) begin
                r_cmp <= wr_data;
            end
            if (w_wr && (w_sel == c_SEL_MASK)) begin
                r_mask <= wr_data[c_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux, combinational for the single-cycle datapath
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        if (w_rd) begin
            case (w_sel)
                c_SEL_CYCLE: rd_data = r_cycle;
                c_SEL_CMP:   rd_data = r_cmp;
                c_SEL_PEND:  rd_data = 32'(r_pend);
                c_SEL_MASK:  rd_data = 32'(r_mask);
                c_SEL_CLAIM: rd_data = w_any ? 32'(w_idx) : 32'hffffffff;
                default:     rd_data = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_sched
// Description : Self-checking bench for irq_sched. Directed scenarios for
//               reset, timer match, priority, masking and set/clear
//               collisions, then randomized bus and irq_src traffic. Every
//               cycle rd_data, hit and irq are compared against a
//               behavioural model of the register map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_sched;

    localparam int unsigned NSRC = 4;
    localparam logic [31:0] BASE = 32'hffff0020;
`ifdef IRQ_SCHED_SYNC_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 0;
`endif

    logic            clock;
    logic            reset;
    logic [31:0]     address;
    logic [31:0]     wr_data;
    logic            MemRead;
    logic            MemWrite;
    logic [NSRC-1:0] irq_src;
    logic [31:0]     rd_data;
    logic            hit;
    logic            irq;

    int n_checks = 0;
    int n_errors = 0;

    irq_sched #(.NSRC(NSRC), .BASE(BASE)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .wr_data  (wr_data),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .irq_src  (irq_src),
        .rd_data  (rd_data),
        .hit      (hit),
        .irq      (irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0]     m_cycle;
    logic [31:0]     m_cmp;
    logic [NSRC:0]   m_pend;
    logic [NSRC:0]   m_mask;
    logic [NSRC-1:0] m_prev;
    logic [NSRC-1:0] m_s1;
    logic [NSRC-1:0] m_s2;

    task automatic m_reset();
        m_cycle = 32'd0;
        m_cmp   = 32'hffffffff;
        m_pend  = '0;
        m_mask  = '0;
        m_prev  = '0;
        m_s1    = '0;
        m_s2    = '0;
    endtask

    function automatic int m_off(input logic [31:0] addr);
        logic [31:0] d;
        d = addr - BASE;
        if (d <= 32'd16 && (d % 4) == 0) return int'(d);
        return -1;
    endfunction

    function automatic logic [31:0] m_lowest(input logic [NSRC:0] v);
        for (int i = 0; i <= int'(NSRC); i++)
            if (v[i]) return 32'(i);
        return 32'hffffffff;
    endfunction

    function automatic logic [31:0] m_read(input logic rd, input logic [31:0] addr);
        case (rd ? m_off(addr) : -1)
            0:       return m_cycle;
            4:       return m_cmp;
            8:       return 32'(m_pend);
            12:      return 32'(m_mask);
            16:      return m_lowest(m_pend & m_mask);
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_advance(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [NSRC-1:0] src);
        logic [NSRC:0]   set;
        logic [NSRC:0]   clr;
        logic [NSRC-1:0] eff;
        logic [31:0]     low;
        int              off;
        off = m_off(addr);
        eff = (c_LAT == 2) ? m_s2 : src;
        set = '0;
        clr = '0;
        set[0] = (m_cycle == m_cmp);
        for (int i = 0; i < int'(NSRC); i++)
            set[i+1] = eff[i] && !m_prev[i];
        if (rd && off == 16) begin
            low = m_lowest(m_pend & m_mask);
            if (low != 32'hffffffff) clr[low[4:0]] = 1'b1;
        end
        if (wr && off == 4)  m_cmp  = data;
        if (wr && off == 8)  clr    = clr | data[NSRC:0];
        if (wr && off == 12) m_mask = data[NSRC:0];
        m_pend  = (m_pend & ~clr) | set;
        m_cycle = m_cycle + 32'd1;
        m_prev  = eff;
        m_s2    = m_s1;
        m_s1    = src;
    endtask

    // ------------------------------------------------------------------
    // Checking and stimulus
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One bus cycle; entered and left just after a rising edge.
    task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [NSRC-1:0] src,
                        output logic [31:0] rd_obs, output logic irq_obs);
        MemRead  = rd;
        MemWrite = wr;
        address  = addr;
        wr_data  = data;
        irq_src  = src;
        @(negedge clock);
        check("rd_data", rd_data, m_read(rd, addr));
        check("hit", 32'(hit), 32'(m_off(addr) >= 0));
        check("irq", 32'(irq), 32'(|(m_pend & m_mask)));
        rd_obs  = rd_data;
        irq_obs = irq;
        @(posedge clock);
        #1;
        m_advance(rd, wr, addr, data, src);
    endtask

    task automatic reset_mid();
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        address  = BASE;
        #2 reset = 1'b0;
        #1;
        check("rst_cycle", rd_data, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        m_reset();
        @(negedge clock);
        reset   = 1'b1;
        MemRead = 1'b0;
        @(posedge clock);
        #1;
        m_advance(1'b0, 1'b0, BASE, 32'd0, irq_src);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]     r;
        logic            q;
        logic [31:0]     tgt;
        logic [NSRC-1:0] src;
        int              g;

        reset    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        address  = 32'd0;
        wr_data  = 32'd0;
        irq_src  = '0;
        m_reset();
        repeat (3) @(posedge clock);
        #1;
        MemRead = 1'b1;
        address = BASE + 32'd4;
        #1;
        check("rst_cmp", rd_data, 32'hffffffff);
        check("rst_irq0", 32'(irq), 32'd0);
        MemRead = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        m_advance(1'b0, 1'b0, BASE, 32'd0, '0);

        // Idle until five edges have passed since release.
        repeat (4) step(0, 0, BASE, 0, '0, r, q);
        step(1, 0, BASE, 0, '0, r, q);
        check("cycle5", r, 32'd5);
        step(1, 0, BASE + 8, 0, '0, r, q);
        check("pend0", r, 32'd0);
        check("irq_idle", 32'(q), 32'd0);

        // Timer match
        step(0, 1, BASE + 12, 32'd1, '0, r, q);
        step(0, 1, BASE + 4, 32'd20, '0, r, q);
        g = 0;
        while (m_cycle != 32'd20 && g < 100) begin
            step(0, 0, BASE, 0, '0, r, q);
            g++;
        end
        check("reach20", m_cycle, 32'd20);
        step(0, 0, BASE, 0, '0, r, q);
        step(1, 0, BASE + 16, 0, '0, r, q);
        check("claim_timer", r, 32'd0);
        check("irq_timer", 32'(q), 32'd1);
        step(1, 0, BASE + 16, 0, '0, r, q);
        check("claim_empty", r, 32'hffffffff);
        check("irq_after_claim", 32'(q), 32'd0);

        // Priority
        step(0, 1, BASE + 12, 32'h1e, '0, r, q);
        step(0, 0, BASE, 0, 4'b1000, r, q);
        step(0, 0, BASE, 0, 4'b0000, r, q);
        step(0, 0, BASE, 0, 4'b0001, r, q);
        repeat (2) step(0, 0, BASE, 0, 4'b0001, r, q);
        step(1, 0, BASE + 16, 0, 4'b0001, r, q);
        check("prio_first", r, 32'd1);
        check("prio_irq", 32'(q), 32'd1);
        step(1, 0, BASE + 16, 0, 4'b0001, r, q);
        check("prio_second", r, 32'd4);
        step(1, 0, BASE + 16, 0, 4'b0001, r, q);
        check("prio_held", r, 32'hffffffff);

        // Masking
        step(0, 1, BASE + 12, 32'd0, 4'b0000, r, q);
        step(0, 0, BASE, 0, 4'b0010, r, q);
        step(0, 0, BASE, 0, 4'b0000, r, q);
        repeat (2) step(0, 0, BASE, 0, '0, r, q);
        step(1, 0, BASE + 8, 0, '0, r, q);
        check("mask_pend", r, 32'h4);
        check("mask_irq0", 32'(q), 32'd0);
        step(0, 1, BASE + 12, 32'h4, '0, r, q);
        step(0, 0, BASE, 0, '0, r, q);
        check("mask_irq1", 32'(q), 32'd1);
        step(0, 1, BASE + 8, 32'h4, '0, r, q);
        step(1, 0, BASE + 8, 0, '0, r, q);
        check("w1c_pend", r, 32'd0);
        check("w1c_irq", 32'(q), 32'd0);

        // Collision: W1C of pend[2] against a rising irq_src[1]
        for (int k = 0; k <= c_LAT; k++)
            step(0, (k == c_LAT), BASE + 8, 32'h4, 4'b0010, r, q);
        step(1, 0, BASE + 8, 0, 4'b0010, r, q);
        check("w1c_collide", 32'(r[2]), 32'd1);
        step(0, 0, BASE, 0, '0, r, q);

        // Collision: claim of bit 0 in the CYCLE==CMP cycle
        step(0, 1, BASE + 12, 32'h1, '0, r, q);
        tgt = m_cycle + 32'd2;
        step(0, 1, BASE + 4, tgt, '0, r, q);
        g = 0;
        while (m_cycle != tgt + 32'd1 && g < 20) begin
            step(0, 0, BASE, 0, '0, r, q);
            g++;
        end
        tgt = m_cycle + 32'd3;
        step(0, 1, BASE + 4, tgt, '0, r, q);
        g = 0;
        while (m_cycle != tgt && g < 20) begin
            step(0, 0, BASE, 0, '0, r, q);
            g++;
        end
        step(1, 0, BASE + 16, 0, '0, r, q);
        check("claim_collide_rd", r, 32'd0);
        step(1, 0, BASE + 8, 0, '0, r, q);
        check("claim_collide_pend", 32'(r[0]), 32'd1);
        check("claim_collide_irq", 32'(q), 32'd1);

        // Randomized traffic
        src = '0;
        for (int i = 0; i < 500; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            int          pick;
            if (i == 250) reset_mid();
            pick = int'($urandom_range(0, 7));
            if (pick <= 4)      a = BASE + 32'(4 * pick);
            else if (pick == 5) a = BASE + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(1, 3));
            else if (pick == 6) a = BASE + 32'd20 + 32'(4 * $urandom_range(0, 3));
            else                a = BASE - 32'd4;
            d = $urandom;
            if (a == BASE + 32'd4) d = m_cycle + 32'($urandom_range(0, 6));
            for (int b = 0; b < int'(NSRC); b++)
                if ($urandom_range(0, 2) == 0) src[b] = ~src[b];
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, d, src, r, q);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
